// File: rtl/escalar_pkg.sv
// rtl/escalar_pkg.sv - shared types and constants for the scalar writeback path
package escalar_pkg;

    localparam int REGISTERS = 16;
    localparam int WIDTH     = 16;
    localparam int AW        = $clog2(REGISTERS);

    // One queued load return; live drops to 0 when a younger ALU write supersedes it.
    typedef struct packed {
        logic             live;
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

    // Register-file write request as presented on we3/a3/wd3.
    typedef struct packed {
        logic             valid;
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-return circular buffer with squash-by-address
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   push, push_rd, push_data   enqueue a load (ignored when full)
//   pop                        dequeue the head (ignored when empty)
//   squash_valid, squash_rd    clear live on every entry (queued or being pushed) with rd==squash_rd
//   head                       entry at the read pointer
//   count                      number of queued entries
module wb_fifo
    import escalar_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AW-1:0]    push_rd,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             squash_valid,
    input  logic [AW-1:0]    squash_rd,
    output wb_entry_t        head,
    output logic [CW-1:0]    count
);

    wb_entry_t     entries_q [DEPTH];
    wb_entry_t     entries_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // Guard internally so a misbehaving caller can never corrupt the pointers.
    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop  && (count_q != '0);

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (squash_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].rd == squash_rd) begin
                    entries_d[i].live = 1'b0;
                end
            end
        end

        if (pop_ok) begin
            entries_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A load arriving alongside a same-address ALU result is older, so it lands dead.
        if (push_ok) begin
            entries_d[wr_ptr_q].live = !(squash_valid && (push_rd == squash_rd));
            entries_d[wr_ptr_q].rd   = push_rd;
            entries_d[wr_ptr_q].data = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/writeback_arbiter_escalar.sv
// rtl/writeback_arbiter_escalar.sv - merges ALU and load results onto the register-file write port
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid, alu_rd, alu_data     ALU result (always wins the port)
//   alu_stall                       FIFO full; upstream must hold alu_valid low
//   mem_valid, mem_rd, mem_data     load return offer
//   mem_ready                       FIFO has room this cycle
//   we3, a3, wd3                    registered register-file write port
//   fifo_count, idle                queued loads; nothing queued and no write pending
module writeback_arbiter_escalar
    import escalar_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [AW-1:0]    alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    output logic             alu_stall,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [AW-1:0]    mem_rd,
    input  logic [WIDTH-1:0] mem_data,
    output logic             we3,
    output logic [AW-1:0]    a3,
    output logic [WIDTH-1:0] wd3,
    output logic [CW-1:0]    fifo_count,
    output logic             idle
);

    wb_entry_t fifo_head;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_nonempty;
    wb_req_t   wb_q, wb_d;

    // Flow control comes only from the registered count: no input-to-output path.
    assign mem_ready     = (fifo_count != CW'(DEPTH));
    assign alu_stall     = (fifo_count == CW'(DEPTH));
    assign fifo_nonempty = (fifo_count != '0);
    assign fifo_push     = mem_valid && mem_ready;
    assign fifo_pop      = !alu_valid && fifo_nonempty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (fifo_push),
        .push_rd      (mem_rd),
        .push_data    (mem_data),
        .pop          (fifo_pop),
        .squash_valid (alu_valid),
        .squash_rd    (alu_rd),
        .head         (fifo_head),
        .count        (fifo_count)
    );

    // A squashed head still takes its slot: it is presented with valid=0.
    always_comb begin
        wb_d = '{valid: 1'b0, rd: wb_q.rd, data: wb_q.data};
        if (alu_valid) begin
            wb_d = '{valid: 1'b1, rd: alu_rd, data: alu_data};
        end else if (fifo_nonempty) begin
            wb_d = '{valid: fifo_head.live, rd: fifo_head.rd, data: fifo_head.data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign we3  = wb_q.valid;
    assign a3   = wb_q.rd;
    assign wd3  = wb_q.data;
    assign idle = !fifo_nonempty && !wb_q.valid;

endmodule
